// File: rtl/branch_resolve_unit.sv
// EX-stage conditional branch resolver: compare, target, prediction check, one registered result.
// Optional saturating perf counters are built only when BRANCH_PERF_CNT_EN is defined.
module branch_resolve_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            br_valid_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] imm_i,
    input  logic            pred_taken_i,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic            cnt_clr_i,
    output logic            res_valid_o,
    output logic            taken_o,
    output logic            mispredict_o,
    output logic            illegal_o,
    output logic [XLEN-1:0] redirect_pc_o,
    output logic [CNT_W-1:0] br_cnt_o,
    output logic [CNT_W-1:0] taken_cnt_o,
    output logic [CNT_W-1:0] mispred_cnt_o
);

    logic            eq, lt_s, lt_u;
    logic            taken_c, illegal_c, mispred_c;
    logic [XLEN-1:0] target, pc_plus4;

    assign eq       = (rs1_i == rs2_i);
    assign lt_s     = ($signed(rs1_i) < $signed(rs2_i));
    assign lt_u     = (rs1_i < rs2_i);
    assign target   = pc_i + imm_i;
    assign pc_plus4 = pc_i + XLEN'(4);

    always_comb begin
        taken_c   = 1'b0;
        illegal_c = 1'b0;
        case (funct3_i)
            3'b000:  taken_c = eq;
            3'b001:  taken_c = !eq;
            3'b100:  taken_c = lt_s;
            3'b101:  taken_c = !lt_s;
            3'b110:  taken_c = lt_u;
            3'b111:  taken_c = !lt_u;
            default: illegal_c = 1'b1;
        endcase
    end

    assign mispred_c = (taken_c != pred_taken_i);

    logic            valid_q, taken_q, mispred_q, illegal_q;
    logic [XLEN-1:0] redirect_q;

    // Flush only drops valid; the payload may hold since consumers qualify with res_valid_o.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q    <= 1'b0;
            taken_q    <= 1'b0;
            mispred_q  <= 1'b0;
            illegal_q  <= 1'b0;
            redirect_q <= '0;
        end else if (flush_i) begin
            valid_q    <= 1'b0;
        end else if (!stall_i) begin
            valid_q    <= br_valid_i;
            taken_q    <= br_valid_i & taken_c;
            mispred_q  <= br_valid_i & mispred_c;
            illegal_q  <= br_valid_i & illegal_c;
            redirect_q <= taken_c ? target : pc_plus4;
        end
    end

    assign res_valid_o   = valid_q;
    assign taken_o       = taken_q;
    assign mispredict_o  = mispred_q;
    assign illegal_o     = illegal_q;
    assign redirect_pc_o = redirect_q;

`ifdef BRANCH_PERF_CNT_EN
    logic             accept;
    logic [CNT_W-1:0] br_cnt_q, br_cnt_d, taken_cnt_q, taken_cnt_d, mispred_cnt_q, mispred_cnt_d;

    assign accept = br_valid_i & !flush_i & !stall_i;

    always_comb begin
        br_cnt_d      = br_cnt_q;
        taken_cnt_d   = taken_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (cnt_clr_i) begin
            br_cnt_d      = '0;
            taken_cnt_d   = '0;
            mispred_cnt_d = '0;
        end else if (accept) begin
            if (br_cnt_q != '1)
                br_cnt_d = br_cnt_q + CNT_W'(1);
            if (taken_c && taken_cnt_q != '1)
                taken_cnt_d = taken_cnt_q + CNT_W'(1);
            if (mispred_c && mispred_cnt_q != '1)
                mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br_cnt_q      <= '0;
            taken_cnt_q   <= '0;
            mispred_cnt_q <= '0;
        end else begin
            br_cnt_q      <= br_cnt_d;
            taken_cnt_q   <= taken_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign br_cnt_o      = br_cnt_q;
    assign taken_cnt_o   = taken_cnt_q;
    assign mispred_cnt_o = mispred_cnt_q;
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr_i;
    assign br_cnt_o       = '0;
    assign taken_cnt_o    = '0;
    assign mispred_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Randomized and directed checks of branch_resolve_unit against a behavioural reference model.
module tb_branch_resolve_unit;
    localparam int XLEN  = 32;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic clk = 1'b0, rst = 1'b1;
    logic br_valid_i = 0, pred_taken_i = 0, stall_i = 0, flush_i = 0, cnt_clr_i = 0;
    logic [2:0] funct3_i = 0;
    logic [XLEN-1:0] rs1_i = 0, rs2_i = 0, pc_i = 0, imm_i = 0;
    logic res_valid_o, taken_o, mispredict_o, illegal_o;
    logic [XLEN-1:0] redirect_pc_o;
    logic [CNT_W-1:0] br_cnt_o, taken_cnt_o, mispred_cnt_o;

    int total = 0, bad = 0;

    // reference model state
    bit e_valid, e_taken, e_mis, e_ill;
    longint e_pc;
    int e_br, e_tk, e_mp;

    branch_resolve_unit #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .br_valid_i(br_valid_i), .funct3_i(funct3_i),
        .rs1_i(rs1_i), .rs2_i(rs2_i), .pc_i(pc_i), .imm_i(imm_i),
        .pred_taken_i(pred_taken_i), .stall_i(stall_i), .flush_i(flush_i),
        .cnt_clr_i(cnt_clr_i), .res_valid_o(res_valid_o), .taken_o(taken_o),
        .mispredict_o(mispredict_o), .illegal_o(illegal_o), .redirect_pc_o(redirect_pc_o),
        .br_cnt_o(br_cnt_o), .taken_cnt_o(taken_cnt_o), .mispred_cnt_o(mispred_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        e_valid = 0; e_taken = 0; e_mis = 0; e_ill = 0; e_pc = 0;
        e_br = 0; e_tk = 0; e_mp = 0;
    endtask

    // Drive one cycle of inputs, advance the model, then step past the edge.
    task automatic apply(input bit bv, input int f3, input longint a, input longint b,
                         input longint pc, input longint imm, input bit pred,
                         input bit stall, input bit flush, input bit clr);
        longint sa, sb;
        bit t, ill;
        br_valid_i = bv; funct3_i = 3'(f3); rs1_i = 32'(a); rs2_i = 32'(b);
        pc_i = 32'(pc); imm_i = 32'(imm); pred_taken_i = pred;
        stall_i = stall; flush_i = flush; cnt_clr_i = clr;
        a = a & 64'hFFFF_FFFF; b = b & 64'hFFFF_FFFF;
        sa = (a >= 64'h8000_0000) ? a - 64'h1_0000_0000 : a;
        sb = (b >= 64'h8000_0000) ? b - 64'h1_0000_0000 : b;
        ill = (f3 == 2 || f3 == 3);
        case (f3)
            0: t = (a == b);   1: t = (a != b);
            4: t = (sa < sb);  5: t = (sa >= sb);
            6: t = (a < b);    7: t = (a >= b);
            default: t = 0;
        endcase
        if (flush) e_valid = 0;
        else if (!stall) begin
            e_valid = bv; e_taken = bv & t; e_ill = bv & ill; e_mis = bv & (t != pred);
            e_pc = (t ? pc + imm : pc + 4) & 64'hFFFF_FFFF;
        end
`ifdef BRANCH_PERF_CNT_EN
        if (clr) begin e_br = 0; e_tk = 0; e_mp = 0; end
        else if (bv && !flush && !stall) begin
            if (e_br < CMAX) e_br++;
            if (t && e_tk < CMAX) e_tk++;
            if (t != pred && e_mp < CMAX) e_mp++;
        end
`endif
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        total++;
        if ({res_valid_o, taken_o, mispredict_o, illegal_o, redirect_pc_o, br_cnt_o, taken_cnt_o, mispred_cnt_o} !== '0) begin
            bad++; $display("FAIL reset: got v=%b t=%b m=%b i=%b pc=%h cnt=%0d/%0d/%0d want all 0",
                res_valid_o, taken_o, mispredict_o, illegal_o, redirect_pc_o, br_cnt_o, taken_cnt_o, mispred_cnt_o);
        end
    endtask

    task automatic test_directed();
        apply(1, 4, 32'hFFFF_FFFF, 1, 32'h100, 32'h40, 0, 0, 0, 0);
        total++;
        if ({res_valid_o, taken_o, mispredict_o, illegal_o, redirect_pc_o} !== {4'b1110, 32'h140}) begin
            bad++; $display("FAIL blt_signed: got %b%b%b%b %h want 1110 00000140",
                res_valid_o, taken_o, mispredict_o, illegal_o, redirect_pc_o);
        end
        apply(1, 6, 32'hFFFF_FFFF, 1, 32'h200, 32'h40, 1, 0, 0, 0);
        total++;
        if ({res_valid_o, taken_o, mispredict_o, illegal_o, redirect_pc_o} !== {4'b1010, 32'h204}) begin
            bad++; $display("FAIL bltu_unsigned: got %b%b%b%b %h want 1010 00000204",
                res_valid_o, taken_o, mispredict_o, illegal_o, redirect_pc_o);
        end
        apply(1, 0, 32'h1234, 32'h1234, 32'hFFFF_FFF0, 32'h20, 1, 0, 0, 0);
        total++;
        if ({res_valid_o, taken_o, redirect_pc_o} !== {2'b11, 32'h10}) begin
            bad++; $display("FAIL beq_wrap: got v=%b t=%b pc=%h want 1 1 00000010", res_valid_o, taken_o, redirect_pc_o);
        end
        apply(0, 0, 5, 5, 32'h300, 32'h8, 1, 0, 0, 0);
        total++;
        if ({res_valid_o, taken_o, mispredict_o, illegal_o} !== 4'b0000) begin
            bad++; $display("FAIL idle_load: got %b%b%b%b want 0000", res_valid_o, taken_o, mispredict_o, illegal_o);
        end
    endtask

    task automatic test_stall_flush();
        apply(1, 1, 1, 2, 32'h400, 32'h10, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            apply(1, 0, 1, 2, 32'h800, 32'h40, 1, 1, 0, 0);
            total++;
            if ({res_valid_o, taken_o, mispredict_o, illegal_o, redirect_pc_o} !== {4'b1110, 32'h410}) begin
                bad++; $display("FAIL stall_hold[%0d]: got %b%b%b%b %h want 1110 00000410",
                    i, res_valid_o, taken_o, mispredict_o, illegal_o, redirect_pc_o);
            end
        end
        apply(1, 1, 1, 2, 32'h900, 32'h40, 0, 1, 1, 0);
        total++;
        if (res_valid_o !== 1'b0) begin
            bad++; $display("FAIL flush_stall: got valid=%b want 0", res_valid_o);
        end
    endtask

    task automatic test_illegal();
        int br0, tk0, mp0;
        br0 = br_cnt_o; tk0 = taken_cnt_o; mp0 = mispred_cnt_o;
        apply(1, 2, 7, 7, 32'h500, 32'h40, 1, 0, 0, 0);
        total++;
        if ({res_valid_o, taken_o, mispredict_o, illegal_o, redirect_pc_o} !== {4'b1011, 32'h504}) begin
            bad++; $display("FAIL illegal: got %b%b%b%b %h want 1011 00000504",
                res_valid_o, taken_o, mispredict_o, illegal_o, redirect_pc_o);
        end
`ifdef BRANCH_PERF_CNT_EN
        total++;
        if (int'(br_cnt_o) !== (br0 + 1 > CMAX ? CMAX : br0 + 1) || int'(taken_cnt_o) !== tk0) begin
            bad++; $display("FAIL illegal_cnt: got br=%0d tk=%0d want br=%0d tk=%0d", br_cnt_o, taken_cnt_o, br0 + 1, tk0);
        end
`else
        total++;
        if (br_cnt_o !== 0 || taken_cnt_o !== 0 || mispred_cnt_o !== 0) begin
            bad++; $display("FAIL cnt_tied: got %0d/%0d/%0d want 0/0/0 (prev %0d/%0d/%0d)",
                br_cnt_o, taken_cnt_o, mispred_cnt_o, br0, tk0, mp0);
        end
`endif
    endtask

    task automatic test_counters();
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 17; i++) apply(1, 0, i, i, 32'h1000, 32'h8, 1, 0, 0, 0);
        total++;
`ifdef BRANCH_PERF_CNT_EN
        if (taken_cnt_o !== 4'd15 || br_cnt_o !== 4'd15 || mispred_cnt_o !== 4'd0) begin
            bad++; $display("FAIL cnt_saturate: got br=%0d tk=%0d mp=%0d want 15 15 0", br_cnt_o, taken_cnt_o, mispred_cnt_o);
        end
`else
        if (taken_cnt_o !== 4'd0) begin
            bad++; $display("FAIL cnt_saturate: got tk=%0d want 0", taken_cnt_o);
        end
`endif
        apply(1, 0, 3, 3, 32'h1000, 32'h8, 0, 0, 0, 1);
        total++;
        if (br_cnt_o !== 0 || taken_cnt_o !== 0 || mispred_cnt_o !== 0) begin
            bad++; $display("FAIL cnt_clear: got %0d/%0d/%0d want 0/0/0", br_cnt_o, taken_cnt_o, mispred_cnt_o);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            longint a, b;
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : longint'($urandom);
            apply($urandom_range(0, 4) != 0, $urandom_range(0, 7), a, b, $urandom, $urandom,
                  $urandom_range(0, 1), $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 30) == 0);
            total++;
            if (res_valid_o !== e_valid || (e_valid &&
                {taken_o, mispredict_o, illegal_o, redirect_pc_o} !== {e_taken, e_mis, e_ill, 32'(e_pc)})) begin
                bad++; $display("FAIL random[%0d]: got %b%b%b%b %h want %b%b%b%b %h", n,
                    res_valid_o, taken_o, mispredict_o, illegal_o, redirect_pc_o,
                    e_valid, e_taken, e_mis, e_ill, 32'(e_pc));
            end
            total++;
            if (int'(br_cnt_o) !== e_br || int'(taken_cnt_o) !== e_tk || int'(mispred_cnt_o) !== e_mp) begin
                bad++; $display("FAIL random_cnt[%0d]: got %0d/%0d/%0d want %0d/%0d/%0d", n,
                    br_cnt_o, taken_cnt_o, mispred_cnt_o, e_br, e_tk, e_mp);
            end
        end
    endtask

    task automatic test_async_reset();
        apply(1, 5, 9, 3, 32'h600, 32'h20, 0, 0, 0, 0);
        #2 rst = 1'b1;
        #1;
        model_reset();
        total++;
        if ({res_valid_o, taken_o, redirect_pc_o, br_cnt_o} !== '0) begin
            bad++; $display("FAIL async_reset: got v=%b t=%b pc=%h br=%0d want all 0",
                res_valid_o, taken_o, redirect_pc_o, br_cnt_o);
        end
        #1 rst = 1'b0;
        apply(1, 5, 9, 3, 32'h600, 32'h20, 0, 0, 0, 0);
        total++;
        if ({res_valid_o, taken_o, mispredict_o, redirect_pc_o} !== {3'b111, 32'h620}) begin
            bad++; $display("FAIL after_reset: got %b%b%b %h want 111 00000620",
                res_valid_o, taken_o, mispredict_o, redirect_pc_o);
        end
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        test_directed();
        test_stall_flush();
        test_illegal();
        test_counters();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
